reg_file_32x32: RTL
===================

// Module: reg_file_32x32
// PURPOSE
//   32-entry x 32-bit register file for the single-cycle datapath; sits directly upstream of
//   the 32-bit 2:1 operand mux: read port B feeds the mux's A input (the immediate feeds B),
//   and read port A feeds the ALU directly.
//   Two combinational read ports, one clocked write port, and a debug read port for the bench.
//   Register 0 is hardwired to zero.
// PARAMETERS
//   DATA_W   32  width of each register and of all data ports
//   ADDR_W   5   register address width (2**ADDR_W entries)
//   BYPASS   1   1: same-cycle write data forwarded to read ports; 0: reads return stored value
// PORTS
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous, active-low reset
//   ra_a     in   ADDR_W  read address, port A (rs)
//   ra_b     in   ADDR_W  read address, port B (rt)
//   rd_a     out  DATA_W  read data, port A (combinational)
//   rd_b     out  DATA_W  read data, port B (combinational, to operand mux)
//   we       in   1       write enable, sampled on rising clk
//   wa       in   ADDR_W  write address (rd/rt selected by the RegDst mux)
//   wd       in   DATA_W  write data (from the MemtoReg mux)
//   dbg_ra   in   ADDR_W  debug read address
//   dbg_rd   out  DATA_W  debug read data (combinational, never bypassed)
//   wr_cnt   out  16      count of committed writes to regs 1..31, for the bench
// BEHAVIOUR
//   Reset: rst_n low clears all 32 registers and wr_cnt to 0 immediately, without waiting for clk;
//     while rst_n is low, rd_a, rd_b and dbg_rd read 0 and writes are ignored.
//   First write after reset: takes effect on the first rising clk with rst_n high.
//   Write: on rising clk, if we=1 and wa!=0, then reg[wa] <= wd and wr_cnt <= wr_cnt+1.
//     wr_cnt saturates at 16'hFFFF (no wrap).
//   Write to reg 0 (we=1, wa=0): no storage change and no wr_cnt increment.
//   Read: rd_x = (ra_x==0) ? 0 : reg[ra_x]; purely combinational, zero latency.
//   Bypass (BYPASS=1): if we=1, wa!=0 and wa==ra_x, then rd_x = wd in the same cycle.
//     Both ports can bypass at once; the bypass never returns a nonzero value for address 0.
//   Bypass (BYPASS=0): rd_x shows the old value until the edge, then the new value.
//   dbg_rd: stored value only; reads 0 for address 0.
//   Reset asserted mid-cycle with we=1: reset wins; the pending write is lost.
//   Storage: a 2-D register array; no latches; X on wa/wd while we=0 has no effect.
// TESTING
//   1 Reset: rst_n=0 at t=3ns (off-edge) -> all dbg_rd reads 0, wr_cnt=0, before the next clk.
//   2 Write/read: we=1, wa=5, wd=32'hDEADBEEF, one clk -> ra_a=5 gives rd_a=32'hDEADBEEF;
//     wr_cnt=1.
//   3 Reg0 guard: we=1, wa=0, wd=32'hFFFFFFFF -> ra_a=ra_b=0 read 0; wr_cnt unchanged.
//   4 Bypass: BYPASS=1, reg7=32'h1, then we=1, wa=7, wd=32'h2, ra_b=7 ->
//     rd_b=2 before the edge; with BYPASS=0, rd_b=1 before the edge and 2 after; dbg_rd=1 before.
//   5 Dual read: reg3=32'hA5A5A5A5, reg31=32'h5A5A5A5A; ra_a=3, ra_b=31 ->
//     both values correct at once; overwriting reg31 leaves reg3 intact.
//   6 Mid-op reset: write reg9=32'h1234, pulse rst_n low for 2ns between edges ->
//     reg9 reads 0, and the next clk with we=1, wa=9, wd=4 gives reg9=4, wr_cnt=1.

Source files
------------

// File: rtl/reg_file_32x32.sv
`timescale 1ns/1ps
// 32x32 register file (reg 0 = 0): two combinational read ports with optional write
// bypass, one clocked write port, debug read port; zero read latency, no backpressure.
module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  output logic [15:0]       wr_cnt
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_hit;

  assign wr_hit = we && (wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wr_cnt <= '0;
    end else if (wr_hit) begin
      regs[wa] <= wd;
      if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // Bypass is gated by rst_n so a write pending during reset never leaks out.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (!rst_n || addr == '0)
      return '0;
    else if (BYPASS != 0 && wr_hit && wa == addr)
      return wd;
    else
      return regs[addr];
  endfunction

  assign rd_a   = read_port(ra_a);
  assign rd_b   = read_port(ra_b);
  assign dbg_rd = (!rst_n || dbg_ra == '0) ? '0 : regs[dbg_ra];

endmodule
